hsv_core_commit_arbiter: RTL and testbench
==========================================

HSV_CORE_COMMIT_ARBITER -- requirements
Module: hsv_core_commit_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, giving the number of execution-unit requesters (range 2..8).
REQ-002 The block SHALL have parameter DATA_W, default 64, giving the width of one commit_data payload.
REQ-003 The block SHALL have port clk_core, input, 1 bit: the single core clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_core, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port flush_req, input, 1 bit: pipeline flush request.
REQ-006 The block SHALL have port flush_ack, output, 1 bit: flush completed.
REQ-007 The block SHALL have port valid_i, input, NUM_REQ bits: per-requester valid.
REQ-008 The block SHALL have port ready_o, output, NUM_REQ bits: per-requester ready.
REQ-009 The block SHALL have port data_i, input, NUM_REQ*DATA_W bits: requester k payload at bits [k*DATA_W +: DATA_W].
REQ-010 The block SHALL have port valid_o, input-side name valid_o, output, 1 bit: commit-stage valid.
REQ-011 The block SHALL have port ready_i, input, 1 bit: commit stage ready.
REQ-012 The block SHALL have port data_o, output, DATA_W bits: granted payload.
REQ-013 The block SHALL have port grant_o, output, clog2(NUM_REQ) bits: index of the requester whose payload is in data_o.

Function
REQ-014 The output stage SHALL be a single registered slot (valid_o, data_o, grant_o); a transfer on either side occurs only when valid and ready are both high on a rising edge.
REQ-015 The slot SHALL accept a new entry in a cycle when state is RUN, and either valid_o=0 or ready_i=1 (load enable).
REQ-016 Arbitration SHALL be round-robin: the grant is the first k with valid_i[k]=1, searching from rr_ptr upward and wrapping NUM_REQ-1 -> 0.
REQ-017 ready_o[k] SHALL be high only when load enable is true and k is the granted index; all other ready_o bits SHALL be 0 (ready_o is one-hot or zero).
REQ-018 ready_o SHALL be combinational from valid_i, rr_ptr, valid_o, ready_i and state; it SHALL NOT depend on data_i.
REQ-019 On a transfer from requester g, the slot SHALL capture data_i[g], grant_o=g, valid_o=1 on the next edge (latency 1 cycle), and rr_ptr SHALL become (g+1) mod NUM_REQ.
REQ-020 If no requester is valid, rr_ptr SHALL hold.
REQ-021 If ready_i=1 and valid_o=1 and no new grant occurs, valid_o SHALL clear on the next edge.
REQ-022 Simultaneous drain and load SHALL sustain one transfer per cycle (full throughput, no bubble).
REQ-023 While valid_o=1 and ready_i=0, data_o and grant_o SHALL remain stable.
REQ-024 The FSM SHALL have states RUN and FLUSH: RUN -> FLUSH when flush_req=1; FLUSH -> RUN when flush_req=0.
REQ-025 In FLUSH all ready_o SHALL be 0, and valid_o SHALL be cleared on the first FLUSH edge regardless of ready_i; the pending entry SHALL be discarded.
REQ-026 flush_ack SHALL be registered: 1 in every cycle the state is FLUSH, otherwise 0; it is therefore high from one cycle after flush_req rises until one cycle after it falls.
REQ-027 A flush_req rising in the same cycle as a would-be transfer SHALL suppress that transfer (RUN with flush_req=1 drives all ready_o to 0).
REQ-028 rr_ptr SHALL reset to 0 on flush.

Reset
REQ-029 While rst_core=1 on an edge, the block SHALL set state=RUN, valid_o=0, data_o=0, grant_o=0, rr_ptr=0, flush_ack=0.
REQ-030 ready_o SHALL be all-zero during any cycle in which rst_core=1.
REQ-031 Reset asserted mid-transfer SHALL discard the slot contents with no transfer on either side.

Verification
REQ-032 Single requester: valid_i=3'b001, data_i[0]=64'h10, ready_i=1 -> ready_o=3'b001; next cycle valid_o=1, data_o=64'h10, grant_o=0.
REQ-033 Fairness: valid_i=3'b111 held for 6 cycles, ready_i=1 -> grant_o sequence 0,1,2,0,1,2, one transfer per cycle.
REQ-034 Backpressure: slot full, ready_i=0 for 4 cycles, valid_i=3'b110 -> ready_o=0, data_o/grant_o stable; on ready_i=1, requester 1 granted in the same cycle, slot holds its data next cycle.
REQ-035 Wrap: rr_ptr=2, valid_i=3'b011 -> grant 0, then rr_ptr=1.
REQ-036 Flush: slot full, flush_req=1 for 3 cycles -> valid_o=0 and flush_ack=1 from next edge, ready_o=0 throughout; flush_ack=0 one cycle after flush_req=0, next grant from index 0.
REQ-037 Reset mid-stream: rst_core=1 for 1 cycle during 3'b111 streaming -> valid_o=0, grant_o=0, next grant index 0.

Source files
------------

// File: rtl/hsv_core_commit_arbiter.sv
// Round-robin commit arbiter: NUM_REQ execution-unit requesters feed one
// registered commit slot, with a flush mode that drops the pending entry.
module hsv_core_commit_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 64
) (
  input  logic                        clk_core,
  input  logic                        rst_core,
  input  logic                        flush_req,
  output logic                        flush_ack,
  input  logic [NUM_REQ-1:0]          valid_i,
  output logic [NUM_REQ-1:0]          ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]   data_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [DATA_W-1:0]           data_o,
  output logic [$clog2(NUM_REQ)-1:0]  grant_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  state_e             state_q, state_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               flush_ack_q, flush_ack_d;

  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_found;
  logic               load_en;
  logic [DATA_W-1:0]  req_data [NUM_REQ];

  // Reset is folded into load_en so no requester sees ready while rst_core is high.
  assign load_en = (state_q == ST_RUN) && !flush_req && !rst_core && (!valid_q || ready_i);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_data[gi] = data_i[gi*DATA_W +: DATA_W];
    assign ready_o[gi]  = load_en && gnt_found && (gnt_idx == IDX_W'(gi));
  end

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [IDX_W:0] cand;
    cand      = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!gnt_found && valid_i[cand[IDX_W-1:0]]) begin
        gnt_idx   = cand[IDX_W-1:0];
        gnt_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    data_d   = data_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_RUN:   if (flush_req)  state_d = ST_FLUSH;
      ST_FLUSH: if (!flush_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    if (flush_req || state_q == ST_FLUSH) begin
      valid_d  = 1'b0;
      rr_ptr_d = '0;
    end else if (load_en && gnt_found) begin
      valid_d  = 1'b1;
      data_d   = req_data[gnt_idx];
      grant_d  = gnt_idx;
      rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
    flush_ack_d = (state_d == ST_FLUSH);
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q     <= ST_RUN;
      valid_q     <= 1'b0;
      data_q      <= '0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      flush_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      flush_ack_q <= flush_ack_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign grant_o   = grant_q;
  assign flush_ack = flush_ack_q;

endmodule

// File: tb/tb_hsv_core_commit_arbiter.sv
// Directed bench: stimulus pushes expected {grant,data} into a scoreboard,
// a negedge monitor pops on every output-side transfer.
module tb_hsv_core_commit_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 64;

  logic                      clk_core = 1'b0;
  logic                      rst_core;
  logic                      flush_req;
  logic                      flush_ack;
  logic [NUM_REQ-1:0]        valid_i;
  logic [NUM_REQ-1:0]        ready_o;
  logic [NUM_REQ*DATA_W-1:0] data_i;
  logic                      valid_o;
  logic                      ready_i;
  logic [DATA_W-1:0]         data_o;
  logic [1:0]                grant_o;

  int checks   = 0;
  int failures = 0;
  logic [65:0] sb_q [$];

  hsv_core_commit_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk_core (clk_core),
    .rst_core (rst_core),
    .flush_req(flush_req),
    .flush_ack(flush_ack),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .grant_o  (grant_o)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Requester k always offers payload 0x10*(k+1).
  function automatic logic [65:0] exp_entry(input logic [NUM_REQ-1:0] onehot);
    logic [1:0] g;
    g = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) if (onehot[k]) g = 2'(k);
    return {g, 64'h10 * (64'(g) + 64'd1)};
  endfunction

  // One cycle: drive inputs after the edge, check ready_o at negedge,
  // and queue the expected commit when sb is set.
  task automatic step(input logic rst, input logic flush, input logic [2:0] v,
                      input logic rdy, input logic [2:0] exp_rdy, input logic sb);
    @(posedge clk_core);
    #1;
    rst_core  = rst;
    flush_req = flush;
    valid_i   = v;
    ready_i   = rdy;
    @(negedge clk_core);
    chk("ready_o", 64'(ready_o), 64'(exp_rdy));
    if (sb && exp_rdy != 3'b000) sb_q.push_back(exp_entry(exp_rdy));
    $display("cyc rst=%0b flush=%0b valid_i=%b ready_i=%0b ready_o=%b valid_o=%0b grant_o=%0d data_o=%0h flush_ack=%0b",
             rst, flush, v, rdy, ready_o, valid_o, grant_o, data_o, flush_ack);
  endtask

  always @(negedge clk_core) begin
    if (rst_core === 1'b0 && valid_o === 1'b1 && ready_i === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected grant=%0d data=%0h expected=none", grant_o, data_o);
      end else begin
        logic [65:0] e;
        e = sb_q.pop_front();
        if ({grant_o, data_o} !== e) begin
          failures++;
          $display("FAIL sb_commit actual grant=%0d data=%0h expected grant=%0d data=%0h",
                   grant_o, data_o, e[65:64], e[63:0]);
        end
      end
    end
  end

  initial begin
    rst_core  = 1'b1;
    flush_req = 1'b0;
    valid_i   = '0;
    ready_i   = 1'b0;
    data_i    = {64'h30, 64'h20, 64'h10};

    // Reset: no ready while held, clean state afterwards.
    step(1, 0, 3'b111, 1, 3'b000, 0);
    step(1, 0, 3'b111, 1, 3'b000, 0);
    step(0, 0, 3'b000, 0, 3'b000, 0);
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_grant_o", 64'(grant_o), 64'd0);
    chk("rst_data_o", data_o, 64'd0);
    chk("rst_flush_ack", 64'(flush_ack), 64'd0);

    // Fairness: 0,1,2,0,1,2 back-to-back.
    step(0, 0, 3'b111, 1, 3'b001, 1);
    step(0, 0, 3'b111, 1, 3'b010, 1);
    step(0, 0, 3'b111, 1, 3'b100, 1);
    step(0, 0, 3'b111, 1, 3'b001, 1);
    step(0, 0, 3'b111, 1, 3'b010, 1);
    step(0, 0, 3'b111, 1, 3'b100, 1);
    step(0, 0, 3'b000, 1, 3'b000, 0);

    // Single requester 0.
    step(0, 0, 3'b001, 1, 3'b001, 1);
    step(0, 0, 3'b000, 1, 3'b000, 0);
    chk("single_valid_o", 64'(valid_o), 64'd1);
    chk("single_data_o", data_o, 64'h10);

    // Wrap: move rr_ptr to 2, then 3'b011 grants 0, then 1.
    step(0, 0, 3'b010, 1, 3'b010, 1);
    step(0, 0, 3'b011, 1, 3'b001, 1);
    step(0, 0, 3'b011, 1, 3'b010, 1);
    step(0, 0, 3'b000, 1, 3'b000, 0);

    // Backpressure: slot holds requester 0 for 4 stalled cycles.
    step(0, 0, 3'b001, 1, 3'b001, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 3'b110, 0, 3'b000, 0);
      chk("bp_valid_o", 64'(valid_o), 64'd1);
      chk("bp_grant_o", 64'(grant_o), 64'd0);
      chk("bp_data_o", data_o, 64'h10);
    end
    step(0, 0, 3'b110, 1, 3'b010, 1);
    step(0, 0, 3'b000, 1, 3'b000, 0);

    // Flush: pending entry from requester 1 is discarded, rr_ptr back to 0.
    step(0, 0, 3'b010, 0, 3'b010, 0);
    step(0, 1, 3'b111, 0, 3'b000, 0);
    chk("fl1_flush_ack", 64'(flush_ack), 64'd0);
    chk("fl1_valid_o", 64'(valid_o), 64'd1);
    step(0, 1, 3'b111, 1, 3'b000, 0);
    chk("fl2_flush_ack", 64'(flush_ack), 64'd1);
    chk("fl2_valid_o", 64'(valid_o), 64'd0);
    step(0, 1, 3'b111, 1, 3'b000, 0);
    chk("fl3_flush_ack", 64'(flush_ack), 64'd1);
    step(0, 0, 3'b111, 1, 3'b000, 0);
    chk("fl4_flush_ack", 64'(flush_ack), 64'd1);
    step(0, 0, 3'b111, 1, 3'b001, 1);
    chk("fl5_flush_ack", 64'(flush_ack), 64'd0);
    step(0, 0, 3'b111, 1, 3'b010, 1);
    step(0, 0, 3'b000, 1, 3'b000, 0);

    // Reset mid-stream: entry loaded just before reset never commits.
    step(0, 0, 3'b111, 1, 3'b100, 1);
    step(0, 0, 3'b111, 1, 3'b001, 0);
    step(1, 0, 3'b111, 1, 3'b000, 0);
    step(0, 0, 3'b111, 1, 3'b001, 1);
    chk("mrst_valid_o", 64'(valid_o), 64'd0);
    chk("mrst_grant_o", 64'(grant_o), 64'd0);
    step(0, 0, 3'b000, 1, 3'b000, 0);
    step(0, 0, 3'b000, 1, 3'b000, 0);

    chk("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
